// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div into HI/LO,
// plus mthi/mtlo writes, mfhi/mflo reads and a busy flag for the hazard unit.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_Start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_Busy,
  output logic [31:0] E_MDURe,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic               div_zero, div_ovf, is_mdu_op;
  logic [31:0]        res_hi, res_lo;

  // Arithmetic datapath; result is captured into tmp at start time
  always_comb begin
    prod_s   = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    prod_u   = {32'd0, E_A} * {32'd0, E_B};
    div_zero = (E_B == 32'd0);
    div_ovf  = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);
    quot_s   = '0;
    rem_s    = '0;
    quot_u   = '0;
    rem_u    = '0;
    if (!div_zero) begin
      quot_u = E_A / E_B;
      rem_u  = E_A % E_B;
      if (!div_ovf) begin
        quot_s = $signed(E_A) / $signed(E_B);
        rem_s  = $signed(E_A) % $signed(E_B);
      end
    end
    is_mdu_op = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU);
    case (E_MDUOp)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (div_zero)     {res_hi, res_lo} = {hi_q, lo_q};
        else if (div_ovf) {res_hi, res_lo} = {32'd0, 32'h8000_0000};
        else              {res_hi, res_lo} = {rem_s, quot_s};
      end
      OP_DIVU: begin
        if (div_zero) {res_hi, res_lo} = {hi_q, lo_q};
        else          {res_hi, res_lo} = {rem_u, quot_u};
      end
      default:  {res_hi, res_lo} = {hi_q, lo_q};
    endcase
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    case (state_q)
      IDLE: begin
        if (E_Start && is_mdu_op) begin
          tmp_hi_d = res_hi;
          tmp_lo_d = res_lo;
          cnt_d    = (E_MDUOp == OP_MULT || E_MDUOp == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
          state_d  = RUN;
        end else if (E_MDUOp == OP_MTHI) begin
          hi_d = E_A;
        end else if (E_MDUOp == OP_MTLO) begin
          lo_d = E_A;
        end
      end
      RUN: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          hi_d    = tmp_hi_q;
          lo_d    = tmp_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
    end
  end

  assign E_Busy = (state_q == RUN);
  assign E_HI   = hi_q;
  assign E_LO   = lo_q;

  // mfhi/mflo read path from committed registers
  always_comb begin
    case (E_MDUOp)
      OP_MFHI: E_MDURe = hi_q;
      OP_MFLO: E_MDURe = lo_q;
      default: E_MDURe = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: table of directed operations plus
// hand-written sequences for back-to-back, busy-ignore and reset-abort cases.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [3:0]  E_MDUOp;
  logic        E_Start;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_Busy;
  logic [31:0] E_MDURe;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  int checks = 0;
  int errors = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .E_MDUOp (E_MDUOp),
    .E_Start (E_Start),
    .E_A     (E_A),
    .E_B     (E_B),
    .E_Busy  (E_Busy),
    .E_MDURe (E_MDURe),
    .E_HI    (E_HI),
    .E_LO    (E_LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op at the next edge, then count cycles with E_Busy high
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    E_MDUOp = op;
    E_A     = a;
    E_B     = b;
    E_Start = (op >= 4'd1 && op <= 4'd4);
    @(posedge clk); #1;
    E_Start = 1'b0;
    E_MDUOp = 4'd0;
    cyc = 0;
    while (E_Busy && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reads(input string name, input logic [31:0] hi, input logic [31:0] lo);
    E_MDUOp = 4'd7; #1;
    check({name, " mfhi"}, E_MDURe, hi);
    E_MDUOp = 4'd8; #1;
    check({name, " mflo"}, E_MDURe, lo);
    E_MDUOp = 4'd0; #1;
    check({name, " nop re"}, E_MDURe, 32'd0);
  endtask

  initial begin
    int cyc;
    int n;

    vecs[0]  = '{"mult neg",     4'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
    vecs[1]  = '{"multu max",    4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2]  = '{"divu 100/7",   4'd4, 32'd100,       32'd7,         32'd2,         32'd14,        10};
    vecs[3]  = '{"div -7/2",     4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4]  = '{"div ovf",      4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
    vecs[5]  = '{"div 7/-2",     4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[6]  = '{"divu big",     4'd4, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 10};
    vecs[7]  = '{"mult minsq",   4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         5};
    vecs[8]  = '{"mthi",         4'd5, 32'h0000_ABCD, 32'd0,         32'h0000_ABCD, 32'd0,         0};
    vecs[9]  = '{"mtlo",         4'd6, 32'h1234_5678, 32'd0,         32'h0000_ABCD, 32'h1234_5678, 0};
    vecs[10] = '{"div by zero",  4'd3, 32'd5,         32'd0,         32'h0000_ABCD, 32'h1234_5678, 10};

    reset   = 1'b0;
    E_MDUOp = 4'd0;
    E_Start = 1'b0;
    E_A     = 32'd0;
    E_B     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(E_Busy), 32'd0);
    check("reset hi", E_HI, 32'd0);
    check("reset lo", E_LO, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check({vecs[i].name, " busy cycles"}, 32'(cyc), 32'(vecs[i].cyc));
      check({vecs[i].name, " hi"}, E_HI, vecs[i].hi);
      check({vecs[i].name, " lo"}, E_LO, vecs[i].lo);
      check_reads(vecs[i].name, vecs[i].hi, vecs[i].lo);
    end

    // Back-to-back: second start held high is only taken once busy is low
    E_MDUOp = 4'd4; E_A = 32'd100; E_B = 32'd7; E_Start = 1'b1;
    @(posedge clk); #1;
    E_MDUOp = 4'd3; E_A = 32'hFFFF_FFF9; E_B = 32'd2;
    n = 0;
    while (E_Busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b first busy", 32'(n), 32'd10);
    check("b2b first hi", E_HI, 32'd2);
    check("b2b first lo", E_LO, 32'd14);
    @(posedge clk); #1;
    check("b2b second accepted", 32'(E_Busy), 32'd1);
    E_Start = 1'b0; E_MDUOp = 4'd0;
    n = 1;
    while (n < 50) begin
      @(posedge clk); #1;
      if (!E_Busy) break;
      n++;
    end
    check("b2b second busy", 32'(n), 32'd10);
    check("b2b second hi", E_HI, 32'hFFFF_FFFF);
    check("b2b second lo", E_LO, 32'hFFFF_FFFD);

    // Start and mthi while busy are ignored; mfhi returns stale HI
    E_MDUOp = 4'd1; E_A = 32'd7; E_B = 32'd6; E_Start = 1'b1;
    @(posedge clk); #1;
    E_MDUOp = 4'd3; E_A = 32'd3; E_B = 32'd1; E_Start = 1'b1;
    @(posedge clk); #1;
    E_Start = 1'b0; E_MDUOp = 4'd5; E_A = 32'h0000_DEAD;
    @(posedge clk); #1;
    E_MDUOp = 4'd7; #1;
    check("busy stale mfhi", E_MDURe, 32'hFFFF_FFFF);
    E_MDUOp = 4'd0;
    n = 3;
    while (n < 50) begin
      @(posedge clk); #1;
      if (!E_Busy) break;
      n++;
    end
    check("ignore busy cycles", 32'(n), 32'd5);
    check("ignore hi", E_HI, 32'd0);
    check("ignore lo", E_LO, 32'd42);
    repeat (12) @(posedge clk);
    #1;
    check("ignore no restart", 32'(E_Busy), 32'd0);
    check("ignore lo held", E_LO, 32'd42);

    // Asynchronous reset in the middle of a mult aborts it
    E_MDUOp = 4'd1; E_A = 32'h0001_0000; E_B = 32'h0001_0000; E_Start = 1'b1;
    @(posedge clk); #1;
    E_Start = 1'b0; E_MDUOp = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort busy", 32'(E_Busy), 32'd0);
    check("abort hi", E_HI, 32'd0);
    check("abort lo", E_LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort no commit hi", E_HI, 32'd0);
    check("abort no commit lo", E_LO, 32'd0);
    check("abort idle", 32'(E_Busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the execute stage of the five-stage pipeline, sitting beside the ALU and consuming the forwarded E-stage operands (post-forwarding RS/RT values).
- Executes mult/multu/div/divu over a fixed multi-cycle latency and commits results into HI/LO.
- Serves mthi/mtlo writes and mfhi/mflo reads.
- Exports a busy flag the hazard unit uses to stall dependent MDU instructions in D.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately
- E_MDUOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; other codes = none
- E_Start  in  1  one-cycle strobe, high with E_MDUOp 1–4 when the instruction enters E
- E_A  in  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source)
- E_B  in  32  forwarded rt value (divisor / multiplier)
- E_Busy  out  1  operation in flight; registered
- E_MDURe  out  32  HI for op 7, LO for op 8, else 0; combinational from committed HI/LO
- E_HI, E_LO  out  32 each  committed HI/LO, for debug/trace

## Operation
- State: HI, LO (committed), tmpHI, tmpLO (pending), cnt (4-bit minimum, sized for max(MULT_CYCLES, DIV_CYCLES)), E_Busy.
- Two states:
  - IDLE (E_Busy=0)
  - RUN (E_Busy=1, cnt counting down)
- IDLE with E_Start=1 and op 1–4:
  - compute result into tmpHI/tmpLO
  - load cnt with MULT_CYCLES or DIV_CYCLES
  - go to RUN
- E_Start=1 with op outside 1–4: ignored.
- RUN, each edge:
  - cnt decrements.
  - When cnt==1 at the edge: HI<=tmpHI, LO<=tmpLO, E_Busy<=0, back to IDLE.
- Arithmetic:
  - mult: signed 64-bit product of E_A×E_B; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - div special case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divisor==0 (div/divu): HI/LO unchanged at commit (tmp loaded with current HI/LO); busy timing is still the full DIV_CYCLES.
- mthi/mtlo (op 5/6) in IDLE: HI<=E_A or LO<=E_A on that edge; no busy.
- mfhi/mflo: combinational read of committed HI/LO.
- While E_Busy=1:
  - E_Start ignored.
  - mthi/mtlo ignored.
  - mfhi/mflo return stale committed values.
  - The hazard unit guarantees none of these reach E; the ignore behaviour is a safety rule that verification checks.
- Simultaneous commit and mthi/mtlo on the same edge cannot occur legally. If it does, the commit wins.

## Timing
- Reset (asynchronous, reset==0): HI=0, LO=0, tmpHI=0, tmpLO=0, cnt=0, E_Busy=0, E_MDURe=0.
- Reset during RUN aborts the operation; the pending result is discarded.
- Start accepted at edge k:
  - E_Busy=1 after edge k through edge k+N−1 (N = MULT_CYCLES or DIV_CYCLES).
  - E_Busy falls, and HI/LO show the result, after edge k+N.
- The first mfhi/mflo able to see the result is one in E during the cycle after edge k+N.
- Hazard stall request is formed outside this block as (E_Start | E_Busy) & D-stage-is-MDU-op. E_Start covers the start cycle, before E_Busy rises.
- Back-to-back: a new start is accepted in the cycle E_Busy is 0. It cannot be accepted on the commit edge itself.
- mthi/mtlo latency: value visible on E_MDURe one cycle after the edge on which it was written.
- cnt wrap: cnt is never decremented below 0; in IDLE it holds 0.

## Test plan
- mult, E_A=0xFFFFFFFD (−3), E_B=5 -> E_Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; mfhi reads 0xFFFFFFFF.
- divu 100/7 then div 0xFFFFFFF9 (−7)/2:
  - divu: busy 10 cycles each; LO=14, HI=2.
  - div: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Check the second start is accepted only once E_Busy=0.
- mtlo 0x12345678, then mflo in the next cycle -> E_MDURe=0x12345678, E_Busy stays 0. Then div by 0 -> after 10 cycles LO still 0x12345678.
- During mult busy: E_Start with div (3/1), then mthi 0xDEAD -> both ignored; the final HI/LO equal the mult result only.
- div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start mult, reset low for 1 cycle at busy cycle 3 -> E_Busy=0, HI=LO=0 immediately (asynchronous), no later commit.
